// File: rtl/wb_pkg.sv
// Shared types and helpers for the eviction write buffer.
package wb_pkg;

  localparam int WB_XLEN  = 32;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [WB_XLEN-3:0] addr;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  function automatic logic [WB_XLEN-3:0] wb_word(input logic [WB_XLEN-1:0] addr);
    return addr[WB_XLEN-1:2];
  endfunction

endpackage

// File: rtl/wb_match.sv
// Combinational newest-first word match over the buffered entries.
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  wb_entry_t          entries [DEPTH],
  input  logic [DEPTH-1:0]   valid,
  input  logic [PW-1:0]      tail,
  input  logic [WB_XLEN-3:0] word,
  output logic               hit,
  output logic [WB_XLEN-1:0] hit_data
);

  logic [PW-1:0] idx;

  // Walk backwards from the slot just behind tail so the first hit is the newest copy.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PW'(i + 1);
      if (!hit && valid[idx] && (entries[idx].addr == word)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/evict_write_buffer.sv
// FIFO write buffer between the data cache and main RAM.
// Build option WB_FWD_EN: serve miss reads from buffered copies instead of stalling.
module evict_write_buffer
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] c_addr,
  input  logic [XLEN-1:0] c_wd,
  input  logic            c_we,
  input  logic            c_re,
  output logic [XLEN-1:0] c_rd,
  output logic            c_stall,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wd,
  output logic            ram_we,
  input  logic [XLEN-1:0] ram_rd,
  output logic            wb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic [XLEN-3:0]  word;
  logic             hit;
  logic [XLEN-1:0]  hit_data;
  logic             full, drain_fire, read_stall, full_stall, enq;

  assign word = wb_word(c_addr);
  assign full = (count == CW'(DEPTH));

  wb_match #(.DEPTH(DEPTH)) u_match (
    .entries  (entries),
    .valid    (valid),
    .tail     (tail),
    .word     (word),
    .hit      (hit),
    .hit_data (hit_data)
  );

`ifdef WB_FWD_EN
  logic unused_sig;
  assign unused_sig = ^c_addr[1:0];
  assign read_stall = 1'b0;
  assign drain_fire = !c_re && (count != '0);
  assign c_rd       = (c_re && hit) ? hit_data : ram_rd;
`else
  logic unused_sig;
  assign unused_sig = ^{c_addr[1:0], hit_data};
  // A stalled read hands the RAM port to the drain so the stale copies leave.
  assign read_stall = c_re && hit;
  assign drain_fire = (count != '0) && (!c_re || hit);
  assign c_rd       = ram_rd;
`endif

  assign full_stall = c_we && full && !drain_fire;
  assign c_stall    = full_stall || read_stall;
  // A stalled request is re-presented next cycle, so nothing of it is taken now.
  assign enq        = c_we && !c_stall;
  assign wb_empty   = (count == '0);

  always_comb begin
    ram_we   = drain_fire;
    ram_addr = {word, 2'b00};
    ram_wd   = '0;
    if (drain_fire) begin
      ram_addr = {entries[head].addr, 2'b00};
      ram_wd   = entries[head].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (drain_fire) begin
        head        <= head + PW'(1);
        valid[head] <= 1'b0;
      end
      if (enq) begin
        tail        <= tail + PW'(1);
        valid[tail] <= 1'b1;
      end
      case ({enq, drain_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail] <= '{addr: word, data: c_wd};
    end
  end

endmodule

// File: tb/tb_evict_write_buffer.sv
// Scoreboard bench for evict_write_buffer: expected RAM writes and fill data are queued by stimulus, checked by a monitor.
module tb_evict_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] c_addr, c_wd, c_rd, ram_addr, ram_wd, ram_rd;
  logic        c_we, c_re, c_stall, ram_we, wb_empty;

  logic [31:0] mem [1024];
  logic [63:0] wq[$];
  logic [31:0] rq[$];
  int checks = 0;
  int errors = 0;

`ifdef WB_FWD_EN
  localparam int EXP_ST = 0;
`else
  localparam int EXP_ST = 1;
`endif

  evict_write_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_wd(c_wd), .c_we(c_we), .c_re(c_re),
    .c_rd(c_rd), .c_stall(c_stall), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_we(ram_we), .ram_rd(ram_rd), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int idx);
    return 32'hA000_0000 | idx;
  endfunction

  initial for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
  assign ram_rd = mem[ram_addr[11:2]];
  always @(posedge clk) if (ram_we) mem[ram_addr[11:2]] <= ram_wd;

  // Monitor: every RAM write and every accepted read is popped against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL ram_write unexpected: got addr=%h data=%h, expected no write", ram_addr, ram_wd);
        end else begin
          logic [63:0] e;
          e = wq.pop_front();
          if ({ram_addr, ram_wd} !== e) begin
            errors++;
            $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                     ram_addr, ram_wd, e[63:32], e[31:0]);
          end
        end
      end
      if (c_re && !c_stall) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL c_rd unexpected read: got %h, expected none", c_rd);
        end else begin
          logic [31:0] r;
          r = rq.pop_front();
          if (c_rd !== r) begin
            errors++;
            $display("FAIL c_rd addr=%h: got %h, expected %h", c_addr, c_rd, r);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    c_we = we; c_re = re; c_addr = a; c_wd = d;
  endtask

  task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                        output int st);
    drive(we, re, a, d);
    st = 0;
    @(negedge clk);
    while (c_stall && st < 20) begin
      st++;
      @(negedge clk);
    end
    if (c_stall) check("access_timeout", 32'(c_stall), 32'd0);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    do begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      n++;
    end while (!wb_empty && n < 16);
    if (!wb_empty) check("drain_timeout", 32'(wb_empty), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst = 1'b1; c_we = 1'b0; c_re = 1'b0; c_addr = '0; c_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; c_addr = 32'h123;
    @(negedge clk);
    check("reset_empty", 32'(wb_empty), 32'd1);
    check("reset_ram_we", 32'(ram_we), 32'd0);
    check("reset_stall", 32'(c_stall), 32'd0);
    check("reset_ram_addr", ram_addr, 32'h120);

    // Single eviction drains on the next idle cycle
    wq.push_back({32'h100, 32'hDEADBEEF});
    drive(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    check("evict_stall", 32'(c_stall), 32'd0);
    check("evict_no_drain", 32'(ram_we), 32'd0);
    drive(1'b0, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check("one_pending", 32'(wb_empty), 32'd0);
    drive(1'b0, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check("drained_empty", 32'(wb_empty), 32'd1);

    // Fill with c_re held, fifth eviction stalls until c_re drops
    for (int i = 0; i < 4; i++) begin
      rq.push_back(init_val(i));
      wq.push_back({32'(i * 4), 32'h30 + 32'(i)});
      access(1'b1, 1'b1, 32'(i * 4), 32'h30 + 32'(i), st);
      check("fill_stall_cycles", 32'(st), 32'd0);
    end
    wq.push_back({32'h10, 32'h34});
    drive(1'b1, 1'b1, 32'h10, 32'h34);
    @(negedge clk);
    check("full_stall", 32'(c_stall), 32'd1);
    @(posedge clk);
    #1;
    c_re = 1'b0;
    @(negedge clk);
    check("full_drain_enq_stall", 32'(c_stall), 32'd0);
    check("full_drain_we", 32'(ram_we), 32'd1);
    wait_empty();

    // Same word evicted twice, then read at an unaligned address in that word
    rq.push_back(init_val(32'h80));
    wq.push_back({32'h200, 32'h11});
    access(1'b1, 1'b1, 32'h200, 32'h11, st);
    check("dup1_stall_cycles", 32'(st), 32'd0);
    rq.push_back(32'h11);
    wq.push_back({32'h200, 32'h22});
    access(1'b1, 1'b1, 32'h200, 32'h22, st);
    check("dup2_stall_cycles", 32'(st), 32'(EXP_ST));
    rq.push_back(32'h22);
    access(1'b0, 1'b1, 32'h202, 32'h0, st);
    check("match_read_stall_cycles", 32'(st), 32'(EXP_ST));
    wait_empty();

    // Simultaneous eviction and read: read wins the port, drain follows
    rq.push_back(init_val(32'hC0));
    access(1'b1, 1'b1, 32'h300, 32'h55, st);
    check("simul_stall_cycles", 32'(st), 32'd0);
    check("simul_no_drain", 32'(ram_we), 32'd0);
    wq.push_back({32'h300, 32'h55});
    drive(1'b0, 1'b0, 32'h300, 32'h0);
    @(negedge clk);
    check("simul_drain_next", 32'(ram_we), 32'd1);
    wait_empty();

    // Reset with three entries pending discards them
    for (int i = 0; i < 3; i++) begin
      rq.push_back(init_val(32'h140 + i));
      access(1'b1, 1'b1, 32'h500 + 32'(4 * i), 32'h60 + 32'(i), st);
    end
    drive(1'b0, 1'b1, 32'h600, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("pending_before_rst", 32'(wb_empty), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; c_re = 1'b0;
    @(negedge clk);
    check("post_rst_empty", 32'(wb_empty), 32'd1);
    check("post_rst_ram_we", 32'(ram_we), 32'd0);
    repeat (4) drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    check("writes_left", 32'(wq.size()), 32'd0);
    check("reads_left", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
